// File: rtl/bus_arbiter.sv
// Round-robin arbiter and registered select sequencer for the 8-source common bus.
// Optional owner pre-emption after HOLD_MAX cycles is enabled by defining BUS_ARB_HOLD_LIMIT_EN.
module bus_arbiter #(
  parameter int unsigned HOLD_MAX = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] req,
  output logic [7:0] gnt,
  output logic [2:0] sel,
  output logic       bus_busy,
  output logic [7:0] hold_cnt
);

`ifdef BUS_ARB_HOLD_LIMIT_EN
  localparam bit HOLD_EN = 1'b1;
`else
  localparam bit HOLD_EN = 1'b0;
`endif

  localparam logic [7:0] HOLD_LIMIT = 8'(HOLD_MAX);

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_e;

  state_e     state_q, state_d;
  logic [2:0] ptr_q, ptr_d;
  logic [2:0] sel_q, sel_d;
  logic [7:0] gnt_q, gnt_d;
  logic       busy_q, busy_d;
  logic [7:0] hold_cnt_q, hold_cnt_d;

  logic [7:0] cand;
  logic       rearb;
  logic       win_found;
  logic [2:0] win_idx;

  // Decide whether this cycle arbitrates and which requests take part.
  // A pre-empted owner is excluded so another requester wins.
  always_comb begin
    cand  = req;
    rearb = 1'b0;
    case (state_q)
      IDLE: rearb = 1'b1;
      BUSY: begin
        if (!req[sel_q]) begin
          rearb = 1'b1;
        end else if (HOLD_EN && (hold_cnt_q == HOLD_LIMIT) && ((req & ~gnt_q) != 8'h00)) begin
          rearb = 1'b1;
          cand  = req & ~gnt_q;
        end
      end
      default: rearb = 1'b1;
    endcase
  end

  // Search ptr+1 .. ptr+8 (mod 8); the last owner is visited last.
  always_comb begin : rr_search
    logic [2:0] idx;
    win_found = 1'b0;
    win_idx   = ptr_q;
    idx       = ptr_q;
    for (int i = 1; i <= 8; i++) begin
      idx = ptr_q + 3'(i);
      if (!win_found && cand[idx]) begin
        win_found = 1'b1;
        win_idx   = idx;
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    sel_d      = sel_q;
    gnt_d      = gnt_q;
    busy_d     = busy_q;
    hold_cnt_d = hold_cnt_q;
    if (rearb) begin
      if (win_found) begin
        state_d    = BUSY;
        ptr_d      = win_idx;
        sel_d      = win_idx;
        gnt_d      = 8'h01 << win_idx;
        busy_d     = 1'b1;
        hold_cnt_d = 8'd1;
      end else begin
        state_d    = IDLE;
        gnt_d      = 8'h00;
        busy_d     = 1'b0;
        hold_cnt_d = 8'd0;
      end
    end else if (hold_cnt_q != 8'hFF) begin
      hold_cnt_d = hold_cnt_q + 8'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      ptr_q      <= 3'd7;
      sel_q      <= 3'd0;
      gnt_q      <= 8'h00;
      busy_q     <= 1'b0;
      hold_cnt_q <= 8'd0;
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      sel_q      <= sel_d;
      gnt_q      <= gnt_d;
      busy_q     <= busy_d;
      hold_cnt_q <= hold_cnt_d;
    end
  end

  assign gnt      = gnt_q;
  assign sel      = sel_q;
  assign bus_busy = busy_q;
  assign hold_cnt = hold_cnt_q;

endmodule

// File: tb/tb_bus_arbiter.sv
// Bench for bus_arbiter: ownership-level reference model feeding an expected queue,
// a negedge monitor that pops and compares, plus invariant and fairness checks.
module tb_bus_arbiter;

  localparam int HOLD_MAX = 4;
`ifdef BUS_ARB_HOLD_LIMIT_EN
  localparam bit HOLD_EN = 1'b1;
`else
  localparam bit HOLD_EN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] req = 8'h00;
  logic [7:0] gnt;
  logic [2:0] sel;
  logic       bus_busy;
  logic [7:0] hold_cnt;

  bus_arbiter #(.HOLD_MAX(HOLD_MAX)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .req      (req),
    .gnt      (gnt),
    .sel      (sel),
    .bus_busy (bus_busy),
    .hold_cnt (hold_cnt)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  logic [19:0] exp_q[$];

  // Reference model: who owns the bus, last owner, cycles held, last select.
  int m_owner = -1;
  int m_ptr   = 7;
  int m_hold  = 0;
  int m_sel   = 0;

  task automatic model_step(input logic [7:0] r, input logic rn);
    logic [7:0] pool;
    bit         arb;
    int         w;
    if (!rn) begin
      m_owner = -1;
      m_ptr   = 7;
      m_sel   = 0;
      m_hold  = 0;
      return;
    end
    arb  = 1'b0;
    pool = r;
    if (m_owner < 0) begin
      arb = 1'b1;
    end else if (!r[m_owner]) begin
      arb = 1'b1;
    end else if (HOLD_EN && m_hold == HOLD_MAX && (r & ~(8'h01 << m_owner)) != 8'h00) begin
      arb  = 1'b1;
      pool = r & ~(8'h01 << m_owner);
    end
    if (arb) begin
      w = -1;
      for (int k = 1; k <= 8; k++) begin
        if (w < 0 && pool[(m_ptr + k) % 8]) w = (m_ptr + k) % 8;
      end
      if (w >= 0) begin
        m_owner = w;
        m_ptr   = w;
        m_sel   = w;
        m_hold  = 1;
      end else begin
        m_owner = -1;
        m_hold  = 0;
      end
    end else begin
      m_hold = (m_hold >= 255) ? 255 : m_hold + 1;
    end
  endtask

  task automatic step(input logic [7:0] r, input logic rn);
    logic [7:0] eg;
    req   = r;
    rst_n = rn;
    model_step(r, rn);
    eg = (m_owner < 0) ? 8'h00 : (8'h01 << m_owner);
    exp_q.push_back({eg, 3'(m_sel), (m_owner >= 0), 8'(m_hold)});
    @(posedge clk);
    #2;
  endtask

  logic [7:0] req_edge = 8'h00;
  logic       rst_edge = 1'b0;
  always @(posedge clk) begin
    req_edge <= req;
    rst_edge <= rst_n;
  end

  int wait_cnt[8];

  always @(negedge clk) begin
    logic [19:0] e;
    logic [19:0] g;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      g = {gnt, sel, bus_busy, hold_cnt};
      checks++;
      if (g !== e) begin
        errors++;
        $display("FAIL scoreboard t=%0t got gnt=%h sel=%0d busy=%b hold=%0d, expected gnt=%h sel=%0d busy=%b hold=%0d",
                 $time, g[19:12], g[11:9], g[8], g[7:0], e[19:12], e[11:9], e[8], e[7:0]);
      end
      checks++;
      if (!$onehot0(gnt)) begin
        errors++;
        $display("FAIL onehot t=%0t gnt=%h, expected zero or one-hot", $time, gnt);
      end
      checks++;
      if (bus_busy !== (|gnt)) begin
        errors++;
        $display("FAIL busy_or t=%0t bus_busy=%b, expected %b", $time, bus_busy, |gnt);
      end
      if (bus_busy === 1'b1) begin
        checks++;
        if (gnt !== (8'h01 << sel)) begin
          errors++;
          $display("FAIL sel_index t=%0t sel=%0d gnt=%h, expected gnt bit at sel", $time, sel, gnt);
        end
      end
      if (rst_edge) begin
        checks++;
        if ((gnt & ~req_edge) != 8'h00) begin
          errors++;
          $display("FAIL grant_nonreq t=%0t gnt=%h req=%h, expected gnt within req", $time, gnt, req_edge);
        end
        for (int i = 0; i < 8; i++) if (!req_edge[i]) wait_cnt[i] = 0;
        if (bus_busy === 1'b1 && hold_cnt == 8'd1) begin
          for (int i = 0; i < 8; i++) begin
            if (gnt[i]) wait_cnt[i] = 0;
            else if (req_edge[i]) wait_cnt[i]++;
          end
          for (int i = 0; i < 8; i++) begin
            checks++;
            if (wait_cnt[i] > 8) begin
              errors++;
              $display("FAIL fairness t=%0t source %0d waited %0d grants, expected at most 8", $time, i, wait_cnt[i]);
            end
          end
        end
      end else begin
        for (int i = 0; i < 8; i++) wait_cnt[i] = 0;
      end
    end
  end

  initial begin
    logic [7:0] r;
    // Reset, then idle bus.
    step(8'h00, 1'b0);
    step(8'h00, 1'b0);
    for (int n = 0; n < 5; n++) step(8'h00, 1'b1);

    // All requesting; each owner drops its request after two cycles of grant.
    for (int n = 0; n < 40; n++) begin
      r = 8'hFF;
      if (m_owner >= 0 && m_hold >= 2) r[m_owner] = 1'b0;
      step(r, 1'b1);
    end

    // Owner 3 releases as source 5 requests on the same edge.
    step(8'h00, 1'b0);
    for (int n = 0; n < 3; n++) step(8'h08, 1'b1);
    for (int n = 0; n < 3; n++) step(8'h20, 1'b1);

    // Two sources held: alternation with hold limit, saturation without.
    step(8'h00, 1'b0);
    for (int n = 0; n < 300; n++) step(8'h03, 1'b1);

    // Reset mid-transfer while source 6 owns the bus; source 0 must win next.
    step(8'h00, 1'b0);
    for (int n = 0; n < 3; n++) step(8'h40, 1'b1);
    step(8'h40, 1'b0);
    for (int n = 0; n < 3; n++) step(8'h41, 1'b1);

    // Randomized traffic with occasional resets.
    r = 8'h00;
    for (int n = 0; n < 10000; n++) begin
      case ($urandom_range(0, 3))
        0: r = 8'($urandom_range(0, 255));
        1: r = r ^ (8'h01 << $urandom_range(0, 7));
        default: ;
      endcase
      step(r, ($urandom_range(0, 499) != 0));
    end

    @(negedge clk);
    #1;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain %0d entries left, expected 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
